// File: rtl/block_sync_module_pkg.sv
// Shared definitions for the receive-side block synchronizer and the stages
// around it (sync-header values, default lock thresholds, lock state encoding).
package block_sync_module_pkg;

    localparam logic [1:0] CTRL_SH = 2'b10;
    localparam logic [1:0] DATA_SH = 2'b01;

    localparam int DEF_VALID_TO_LOCK     = 64;
    localparam int DEF_WINDOW            = 1024;
    localparam int DEF_INVALID_TO_UNLOCK = 65;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == CTRL_SH) || (sh == DATA_SH);
    endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Sync-header lock state machine: counts good/bad headers on qualified blocks
// and requests a slip whenever alignment must move on.
module block_lock_fsm
    import block_sync_module_pkg::*;
#(
    parameter int N_VALID_TO_LOCK     = DEF_VALID_TO_LOCK,
    parameter int N_WINDOW            = DEF_WINDOW,
    parameter int N_INVALID_TO_UNLOCK = DEF_INVALID_TO_UNLOCK
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_strobe,
    input  logic i_sh_valid,
    output logic o_block_lock,
    output logic o_slip_req
);

    localparam int SH_W  = $clog2(N_WINDOW + 1);
    localparam int INV_W = $clog2(N_INVALID_TO_UNLOCK + 1);

    localparam logic [SH_W-1:0]  LOCK_LIM   = SH_W'(N_VALID_TO_LOCK);
    localparam logic [SH_W-1:0]  WINDOW_LIM = SH_W'(N_WINDOW);
    localparam logic [INV_W-1:0] UNLOCK_LIM = INV_W'(N_INVALID_TO_UNLOCK);

    lock_state_t      state, state_next;
    logic [SH_W-1:0]  sh_cnt, sh_cnt_next, sh_inc;
    logic [INV_W-1:0] inv_cnt, inv_cnt_next, inv_inc;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state   <= UNLOCKED;
            sh_cnt  <= '0;
            inv_cnt <= '0;
        end else begin
            state   <= state_next;
            sh_cnt  <= sh_cnt_next;
            inv_cnt <= inv_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        sh_cnt_next  = sh_cnt;
        inv_cnt_next = inv_cnt;
        o_slip_req   = 1'b0;
        sh_inc       = sh_cnt + 1'b1;
        inv_inc      = inv_cnt + {{(INV_W-1){1'b0}}, ~i_sh_valid};

        if (i_strobe) begin
            case (state)
                UNLOCKED: begin
                    if (!i_sh_valid) begin
                        o_slip_req   = 1'b1;
                        sh_cnt_next  = '0;
                        inv_cnt_next = '0;
                    end else if (sh_inc == LOCK_LIM) begin
                        state_next   = LOCKED;
                        sh_cnt_next  = '0;
                        inv_cnt_next = '0;
                    end else begin
                        sh_cnt_next  = sh_inc;
                    end
                end
                LOCKED: begin
                    // Losing lock takes priority over a window rollover on the same block.
                    if (inv_inc == UNLOCK_LIM) begin
                        o_slip_req   = 1'b1;
                        state_next   = UNLOCKED;
                        sh_cnt_next  = '0;
                        inv_cnt_next = '0;
                    end else if (sh_inc == WINDOW_LIM) begin
                        sh_cnt_next  = '0;
                        inv_cnt_next = '0;
                    end else begin
                        sh_cnt_next  = sh_inc;
                        inv_cnt_next = inv_inc;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
    end

    assign o_block_lock = (state == LOCKED);

endmodule

// File: rtl/block_sync_module.sv
// Block synchronizer top: slip aligner over a two-word window feeding the
// sync-header lock state machine.
module block_sync_module
    import block_sync_module_pkg::*;
#(
    parameter int LEN_CODED_BLOCK     = 66,
    parameter int NB_SH               = 2,
    parameter int N_VALID_TO_LOCK     = DEF_VALID_TO_LOCK,
    parameter int N_WINDOW            = DEF_WINDOW,
    parameter int N_INVALID_TO_UNLOCK = DEF_INVALID_TO_UNLOCK,
    parameter int NB_OFFSET           = $clog2(LEN_CODED_BLOCK)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
    output logic [LEN_CODED_BLOCK-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_block_lock,
    output logic                       o_slip,
    output logic [NB_OFFSET-1:0]       o_offset
);

    localparam logic [NB_OFFSET-1:0] LAST_OFFSET = NB_OFFSET'(LEN_CODED_BLOCK - 1);

    logic [LEN_CODED_BLOCK-1:0]   prev;
    logic [NB_OFFSET-1:0]         offset;
    logic [2*LEN_CODED_BLOCK-1:0] window;
    logic [LEN_CODED_BLOCK-1:0]   candidate;
    logic [NB_SH-1:0]             header;
    logic                         strobe;
    logic                         sh_valid;
    logic                         slip_req;

    assign strobe = i_enable && i_valid;
    assign window = {prev, i_data};

    // Offset 0 selects the older word; each slip moves the boundary one bit later in time.
    assign candidate = LEN_CODED_BLOCK'(window >> (LEN_CODED_BLOCK - int'(offset)));
    assign header    = candidate[LEN_CODED_BLOCK-1 -: NB_SH];
    assign sh_valid  = (header == NB_SH'(CTRL_SH)) || (header == NB_SH'(DATA_SH));

    block_lock_fsm #(
        .N_VALID_TO_LOCK     (N_VALID_TO_LOCK),
        .N_WINDOW            (N_WINDOW),
        .N_INVALID_TO_UNLOCK (N_INVALID_TO_UNLOCK)
    ) u_lock_fsm (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_strobe     (strobe),
        .i_sh_valid   (sh_valid),
        .o_block_lock (o_block_lock),
        .o_slip_req   (slip_req)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            prev    <= '0;
            o_data  <= '0;
            offset  <= '0;
            o_valid <= 1'b0;
            o_slip  <= 1'b0;
        end else begin
            o_valid <= strobe;
            o_slip  <= slip_req;
            if (strobe) begin
                prev   <= i_data;
                o_data <= candidate;
                if (slip_req) begin
                    offset <= (offset == LAST_OFFSET) ? '0 : offset + 1'b1;
                end
            end
        end
    end

    assign o_offset = offset;

endmodule

// File: tb/tb_block_sync_module.sv
// Self-checking bench for block_sync_module: vector table, directed lock/slip
// sequences and a randomized stream, all checked against a behavioural model.
module tb_block_sync_module;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_valid;
    logic [65:0] i_data;
    logic [65:0] o_data;
    logic        o_valid;
    logic        o_block_lock;
    logic        o_slip;
    logic [6:0]  o_offset;

    block_sync_module dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_block_lock (o_block_lock),
        .o_slip       (o_slip),
        .o_offset     (o_offset)
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [65:0] m_prev, m_data;
    logic        m_valid, m_slip, m_lock;
    int          m_off, m_sh, m_inv;

    // Bench bookkeeping derived from the DUT outputs
    int n_blk, slips, lock_blk;
    logic bad [0:4095];

    typedef struct {
        logic        en;
        logic        vld;
        logic [65:0] data;
        logic        exp_valid;
        logic [65:0] exp_data;
        logic        exp_slip;
        logic [6:0]  exp_off;
        logic        exp_lock;
    } vec_t;
    vec_t vecs [5];

    function automatic logic [65:0] rand66();
        logic [65:0] x;
        x[31:0]  = $urandom();
        x[63:32] = $urandom();
        x[65:64] = 2'($urandom());
        return x;
    endfunction

    // Continuous bit stream of blocks starting s bits into the lane; headers alternate
    // 01/10, payload bits equal the next block's first header bit, so every
    // misaligned header sampled during the search reads 00 or 11.
    function automatic logic stream_bit(int q, int s);
        int r, k;
        logic h0;
        if (q < s) return 1'b0;
        r  = (q - s) % 66;
        k  = (q - s) / 66;
        h0 = k[0];
        if (r == 0) return bad[k] ? 1'b0 : h0;
        if (r == 1) return bad[k] ? 1'b0 : ~h0;
        return ~h0;
    endfunction

    function automatic logic [65:0] gen_word(int w, int s);
        logic [65:0] x;
        for (int j = 0; j < 66; j++) x[65-j] = stream_bit(66 * (w - 1) + j, s);
        return x;
    endfunction

    task automatic model_slip();
        m_off  = (m_off + 1) % 66;
        m_slip = 1'b1;
        m_sh   = 0;
        m_inv  = 0;
        m_lock = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic e, input logic v, input logic [65:0] d);
        logic [131:0] win;
        logic [65:0]  cand;
        logic         hv;
        if (!r) begin
            m_prev = '0; m_data = '0; m_off = 0; m_sh = 0; m_inv = 0;
            m_valid = 1'b0; m_slip = 1'b0; m_lock = 1'b0;
        end else if (e && v) begin
            win = {m_prev, d};
            for (int k = 0; k < 66; k++) cand[65-k] = win[131 - m_off - k];
            m_valid = 1'b1;
            m_slip  = 1'b0;
            m_data  = cand;
            hv      = (cand[65:64] == 2'b01) || (cand[65:64] == 2'b10);
            if (!m_lock) begin
                if (!hv) model_slip();
                else begin
                    m_sh++;
                    if (m_sh == 64) begin m_lock = 1'b1; m_sh = 0; m_inv = 0; end
                end
            end else begin
                m_sh++;
                if (!hv) m_inv++;
                if (m_inv == 65) model_slip();
                else if (m_sh == 1024) begin m_sh = 0; m_inv = 0; end
            end
            m_prev = d;
        end else begin
            m_valid = 1'b0;
            m_slip  = 1'b0;
        end
    endtask

    task automatic check_model();
        n_cmp++;
        if (o_data !== m_data || o_valid !== m_valid || o_block_lock !== m_lock ||
            o_slip !== m_slip || o_offset !== 7'(m_off)) begin
            n_bad++;
            $display("FAIL model t=%0t: got data=%h v=%b lock=%b slip=%b off=%0d, need data=%h v=%b lock=%b slip=%b off=%0d",
                     $time, o_data, o_valid, o_block_lock, o_slip, o_offset,
                     m_data, m_valid, m_lock, m_slip, m_off);
        end
    endtask

    task automatic check_val(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, need %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic v, input logic [65:0] d);
        i_reset = r; i_enable = e; i_valid = v; i_data = d;
        model_edge(r, e, v, d);
        if (!r) begin n_blk = 0; slips = 0; lock_blk = 0; end
        else if (e && v) n_blk++;
        @(posedge i_clock);
        #1;
        check_model();
        if (r && e && v) begin
            if (o_slip) slips++;
            if (o_block_lock && lock_blk == 0) lock_blk = n_blk;
        end
    endtask

    task automatic qblk(input int s);
        step(1'b1, 1'b1, 1'b1, gen_word(n_blk + 1, s));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b1, rand66());
    endtask

    initial begin
        int s;
        logic r, e, v;
        i_reset = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_data = '0;
        for (int k = 0; k < 4096; k++) bad[k] = 1'b0;

        // Reset state
        do_reset();
        do_reset();
        check_val("reset_valid", o_valid, 0);
        check_val("reset_data_zero", (o_data == 66'h0) ? 1 : 0, 1);
        check_val("reset_lock", o_block_lock, 0);
        check_val("reset_slip", o_slip, 0);
        check_val("reset_offset", o_offset, 0);

        // Vector table, applied straight after reset (prev = 0, offset = 0)
        vecs[0] = '{1'b1, 1'b1, 66'h0_8000_0000_0000_0000, 1'b1, 66'h0,                     1'b1, 7'd1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b0, 66'h0,                     1'b0, 7'd1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b0, 66'h0,                     1'b0, 7'd1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b1, 66'h1_0000_0000_0000_0001, 1'b0, 7'd1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 66'h0,                     1'b1, 66'h3_FFFF_FFFF_FFFF_FFFE, 1'b1, 7'd2, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, vecs[i].en, vecs[i].vld, vecs[i].data);
            n_cmp++;
            if (o_valid !== vecs[i].exp_valid || o_data !== vecs[i].exp_data || o_slip !== vecs[i].exp_slip ||
                o_offset !== vecs[i].exp_off || o_block_lock !== vecs[i].exp_lock) begin
                n_bad++;
                $display("FAIL vec%0d: got v=%b data=%h slip=%b off=%0d lock=%b, need v=%b data=%h slip=%b off=%0d lock=%b",
                         i, o_valid, o_data, o_slip, o_offset, o_block_lock, vecs[i].exp_valid,
                         vecs[i].exp_data, vecs[i].exp_slip, vecs[i].exp_off, vecs[i].exp_lock);
            end
        end

        // Skew of 5 bits with gaps, then window hold and loss of lock
        for (int k = 98; k <= 161; k++) bad[k] = 1'b1;
        for (int k = 1098; k <= 1162; k++) bad[k] = 1'b1;
        do_reset();
        for (int n = 1; n <= 1170; n++) begin
            if (n == 36) begin
                for (int g = 0; g < 10; g++) step(1'b1, 1'b1, 1'b0, rand66());
                for (int g = 0; g < 10; g++) step(1'b1, 1'b0, 1'b1, rand66());
            end
            qblk(5);
            if (n == 68) check_val("skew_not_locked_yet", o_block_lock, 0);
            if (n == 69) begin
                check_val("skew_slips", slips, 5);
                check_val("skew_offset", o_offset, 5);
                check_val("skew_lock_block", lock_blk, 69);
            end
            if (n == 1093) check_val("window_lock_held", o_block_lock, 1);
            if (n == 1163) check_val("second_window_lock_held", o_block_lock, 1);
            if (n == 1164) begin
                check_val("unlock_lock", o_block_lock, 0);
                check_val("unlock_slip", o_slip, 1);
                check_val("unlock_offset", o_offset, 6);
                check_val("unlock_slips", slips, 6);
            end
        end
        for (int k = 0; k < 4096; k++) bad[k] = 1'b0;

        // Offset wrap from 65 to 0
        do_reset();
        for (int n = 1; n <= 65; n++) step(1'b1, 1'b1, 1'b1, 66'h0);
        check_val("wrap_offset_65", o_offset, 65);
        check_val("wrap_slips_65", slips, 65);
        step(1'b1, 1'b1, 1'b1, 66'h0);
        check_val("wrap_offset_0", o_offset, 0);
        check_val("wrap_slip_pulse", o_slip, 1);

        // Reset while locked at offset 12
        do_reset();
        for (int n = 1; n <= 76; n++) qblk(12);
        check_val("off12_lock", o_block_lock, 1);
        check_val("off12_offset", o_offset, 12);
        check_val("off12_lock_block", lock_blk, 76);
        step(1'b0, 1'b1, 1'b1, rand66());
        check_val("midlock_reset_valid", o_valid, 0);
        check_val("midlock_reset_data_zero", (o_data == 66'h0) ? 1 : 0, 1);
        check_val("midlock_reset_lock", o_block_lock, 0);
        check_val("midlock_reset_slip", o_slip, 0);
        check_val("midlock_reset_offset", o_offset, 0);

        // Randomized stream against the model
        for (int k = 0; k < 4096; k++) bad[k] = ($urandom_range(0, 199) == 0);
        do_reset();
        s = $urandom_range(1, 64);
        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 1499) != 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 9) != 0);
            if (r && e && v) step(r, e, v, gen_word(n_blk + 1, s));
            else step(r, e, v, rand66());
            if (!r) s = $urandom_range(1, 64);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
